// File: rtl/sample_window_ctrl_pkg.sv
// Shared team-12 audio-path definitions: window sequencer states, widths and the stereo mixer.
package sample_window_ctrl_pkg;

  localparam int unsigned WINDOW_MAX = 128;
  localparam int unsigned SampleW    = 8;
  localparam int unsigned MonoW      = 9;
  localparam int unsigned SumW       = 16;
  localparam int unsigned CountW     = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StCollect,
    StDrain,
    StCapture
  } state_e;

  // Zero-extended stereo-to-mono sum; 255 + 255 = 510 needs the ninth bit.
  function automatic logic [MonoW-1:0] mix_pair(input logic [SampleW-1:0] left,
                                                input logic [SampleW-1:0] right);
    return {1'b0, left} + {1'b0, right};
  endfunction

endpackage

// File: rtl/sample_window_ctrl_if.sv
// Sample handshake, accumulator strobes/feedback and window result bundle.
interface sample_window_ctrl_if;
  import sample_window_ctrl_pkg::*;

  logic                en;
  logic                sample_valid;
  logic [SampleW-1:0]  sample_left;
  logic [SampleW-1:0]  sample_right;
  logic [SumW-1:0]     current_sum;
  logic                sample_ready;
  logic [MonoW-1:0]    sample_mono;
  logic                accumulate;
  logic                clear;
  logic [SumW-1:0]     window_sum;
  logic                window_done;
  logic                overrun;

  // The sequencer is the slave of the sample stream.
  modport slave (
    input  en, sample_valid, sample_left, sample_right, current_sum,
    output sample_ready, sample_mono, accumulate, clear, window_sum, window_done, overrun
  );

  modport master (
    output en, sample_valid, sample_left, sample_right, current_sum,
    input  sample_ready, sample_mono, accumulate, clear, window_sum, window_done, overrun
  );

endinterface

// File: rtl/sample_window_ctrl.sv
// Frames fixed-length windows for the accumulator: mixes accepted stereo pairs, strobes
// clear/accumulate, and latches each completed window total.
module sample_window_ctrl
  import sample_window_ctrl_pkg::*;
#(
  parameter int unsigned WINDOW = 64
) (
  input logic                 MHz10,
  input logic                 nrst,
  sample_window_ctrl_if.slave bus
);

  if (WINDOW == 0 || WINDOW > WINDOW_MAX) begin : g_bad_window
    $error("sample_window_ctrl: WINDOW must be within 1..WINDOW_MAX");
  end

  localparam logic [CountW-1:0] LastCount = CountW'(WINDOW - 1);

  state_e              state_q, state_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [MonoW-1:0]    sample_mono_q, sample_mono_d;
  logic                accumulate_q, accumulate_d;
  logic [SumW-1:0]     window_sum_q, window_sum_d;
  logic                window_done_q, window_done_d;
  logic                overrun_q, overrun_d;
  logic                accept;

  // A pair offered while en is low is not taken even if the state still reads COLLECT.
  assign accept = bus.en && bus.sample_valid && (state_q == StCollect);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    sample_mono_d = sample_mono_q;
    accumulate_d  = 1'b0;
    window_sum_d  = window_sum_q;
    window_done_d = 1'b0;
    overrun_d     = 1'b0;

    if (!bus.en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StClear;
        StClear: begin
          state_d = StCollect;
          count_d = '0;
        end
        StCollect: begin
          if (accept) begin
            sample_mono_d = mix_pair(bus.sample_left, bus.sample_right);
            accumulate_d  = 1'b1;
            count_d       = count_q + 1'b1;
            if (count_q == LastCount) state_d = StDrain;
          end
        end
        StDrain:   state_d = StCapture;
        StCapture: begin
          state_d       = StClear;
          window_sum_d  = bus.current_sum;
          window_done_d = 1'b1;
        end
        default:   state_d = StIdle;
      endcase
      overrun_d = bus.sample_valid && (state_q inside {StClear, StDrain, StCapture});
    end
  end

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      state_q       <= StIdle;
      count_q       <= '0;
      sample_mono_q <= '0;
      accumulate_q  <= 1'b0;
      window_sum_q  <= '0;
      window_done_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      sample_mono_q <= sample_mono_d;
      accumulate_q  <= accumulate_d;
      window_sum_q  <= window_sum_d;
      window_done_q <= window_done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.clear        = (state_q == StClear);
  assign bus.sample_ready = (state_q == StCollect);
  assign bus.sample_mono  = sample_mono_q;
  assign bus.accumulate   = accumulate_q;
  assign bus.window_sum   = window_sum_q;
  assign bus.window_done  = window_done_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_sample_window_ctrl.sv
// Drives a 4-sample and a 128-sample window instance with identical stimulus and compares
// every output each cycle against a cycle-counting reference of the windowing rules.
module tb_sample_window_ctrl;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  sample_window_ctrl_if b4 ();
  sample_window_ctrl_if b128 ();

  sample_window_ctrl #(.WINDOW(4)) u_dut4 (
    .MHz10 (clk),
    .nrst  (nrst),
    .bus   (b4)
  );

  sample_window_ctrl #(.WINDOW(128)) u_dut128 (
    .MHz10 (clk),
    .nrst  (nrst),
    .bus   (b128)
  );

  // Neighbouring accumulator stages feeding current_sum back.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) b4.current_sum <= '0;
    else if (b4.en) begin
      if (b4.clear) b4.current_sum <= '0;
      else if (b4.accumulate) b4.current_sum <= b4.current_sum + 16'(b4.sample_mono);
    end
  end

  always @(posedge clk or negedge nrst) begin
    if (!nrst) b128.current_sum <= '0;
    else if (b128.en) begin
      if (b128.clear) b128.current_sum <= '0;
      else if (b128.accumulate) b128.current_sum <= b128.current_sum + 16'(b128.sample_mono);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: m_gap counts the non-ready cycles still to come (3 after a full window, 1 after
  // enable); the window result is emitted as the gap passes from 2 to 1.
  int win_len [2] = '{4, 128};
  bit m_idle [2];
  int m_gap  [2];
  int m_n    [2];
  int m_sum  [2];
  int e_mono [2];
  int e_win  [2];
  bit e_acc  [2];
  bit e_done [2];
  bit e_ovr  [2];

  task automatic model_reset(input int d);
    m_idle[d] = 1'b1;
    m_gap[d]  = 0;
    m_n[d]    = 0;
    m_sum[d]  = 0;
    e_mono[d] = 0;
    e_win[d]  = 0;
    e_acc[d]  = 1'b0;
    e_done[d] = 1'b0;
    e_ovr[d]  = 1'b0;
  endtask

  task automatic model_edge(input int d, input bit e, input bit v, input int l, input int r);
    bit rdy;
    rdy       = !m_idle[d] && m_gap[d] == 0;
    e_acc[d]  = 1'b0;
    e_done[d] = 1'b0;
    e_ovr[d]  = 1'b0;
    if (!e) begin
      m_idle[d] = 1'b1;
    end else if (m_idle[d]) begin
      m_idle[d] = 1'b0;
      m_gap[d]  = 1;
      m_n[d]    = 0;
      m_sum[d]  = 0;
    end else if (rdy) begin
      if (v) begin
        e_acc[d]  = 1'b1;
        e_mono[d] = l + r;
        m_sum[d] += l + r;
        m_n[d]++;
        if (m_n[d] == win_len[d]) m_gap[d] = 3;
      end
    end else begin
      if (v) e_ovr[d] = 1'b1;
      if (m_gap[d] == 2) begin
        e_win[d]  = m_sum[d];
        e_done[d] = 1'b1;
        m_n[d]    = 0;
        m_sum[d]  = 0;
      end
      m_gap[d]--;
    end
  endtask

  task automatic check_dut(input int d);
    logic rdy, clr, acc, done, ovr;
    logic [8:0]  mono;
    logic [15:0] ws;
    string p;
    if (d == 0) begin
      rdy = b4.sample_ready; clr = b4.clear; acc = b4.accumulate; done = b4.window_done;
      ovr = b4.overrun; mono = b4.sample_mono; ws = b4.window_sum; p = "w4";
    end else begin
      rdy = b128.sample_ready; clr = b128.clear; acc = b128.accumulate; done = b128.window_done;
      ovr = b128.overrun; mono = b128.sample_mono; ws = b128.window_sum; p = "w128";
    end
    check({p, "_ready"},      32'(rdy),  32'(!m_idle[d] && m_gap[d] == 0));
    check({p, "_clear"},      32'(clr),  32'(!m_idle[d] && m_gap[d] == 1));
    check({p, "_accumulate"}, 32'(acc),  32'(e_acc[d]));
    check({p, "_mono"},       32'(mono), 32'(e_mono[d]));
    check({p, "_window_sum"}, 32'(ws),   32'(e_win[d]));
    check({p, "_window_done"}, 32'(done), 32'(e_done[d]));
    check({p, "_overrun"},    32'(ovr),  32'(e_ovr[d]));
  endtask

  task automatic step(input bit e, input bit v, input int l, input int r);
    b4.en = e;                b128.en = e;
    b4.sample_valid = v;      b128.sample_valid = v;
    b4.sample_left = 8'(l);   b128.sample_left = 8'(l);
    b4.sample_right = 8'(r);  b128.sample_right = 8'(r);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d, e, v, l, r);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  int mono_ref [4] = '{3, 7, 11, 15};
  int done_cnt;

  initial begin
    nrst = 1'b0;
    b4.en = 1'b0;           b128.en = 1'b0;
    b4.sample_valid = 1'b0; b128.sample_valid = 1'b0;
    b4.sample_left = '0;    b128.sample_left = '0;
    b4.sample_right = '0;   b128.sample_right = '0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    nrst = 1'b1;

    // Disabled: offered pairs are neither taken nor flagged as overrun.
    step(0, 1, 9, 9);
    step(0, 1, 9, 9);

    // Full-scale back-to-back window; valid held through the gap.
    for (int i = 0; i < 12; i++) step(1, 1, 255, 255);
    check("w4_full_scale_sum", 32'(b4.window_sum), 32'd2040);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Spaced pairs.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 2 * i + 1, 2 * i + 2);
      check("w4_mono_seq", 32'(b4.sample_mono), 32'(mono_ref[i]));
      step(1, 0, 0, 0);
    end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("w4_spaced_sum", 32'(b4.window_sum), 32'd36);

    // Abort after two pairs, then a fresh window.
    step(1, 1, 10, 20);
    step(1, 1, 10, 20);
    step(0, 1, 10, 20);
    step(0, 0, 0, 0);
    check("w4_abort_keeps_sum", 32'(b4.window_sum), 32'd36);
    step(1, 0, 0, 0);
    check("w4_reenable_clear", 32'(b4.clear), 32'd1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 10, 20);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check("w4_fresh_sum", 32'(b4.window_sum), 32'd120);

    // Randomized traffic with occasional enable drops.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 9) < 7,
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    // Two full-scale 128-sample windows: largest total the 16-bit sum must hold.
    step(0, 0, 0, 0);
    done_cnt = 0;
    for (int i = 0; i < 270; i++) begin
      step(1, 1, 255, 255);
      if (b128.window_done) done_cnt++;
    end
    check("w128_done_count", 32'(done_cnt), 32'd2);
    check("w128_max_sum", 32'(b128.window_sum), 32'd65280);

    // Asynchronous reset in the middle of a window.
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 5, 5);
    step(1, 1, 5, 5);
    #2;
    nrst = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    step(1, 0, 0, 0);
    check("rst_then_clear", 32'(b4.clear), 32'd1);
    step(1, 0, 0, 0);
    check("rst_then_ready", 32'(b4.sample_ready), 32'd1);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 1);
    check("rst_window_sum", 32'(b4.window_sum), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sample_window_ctrl.md
# sample_window_ctrl

Upstream sequencer for the `accumulator` stage in the team 12 audio path. It accepts stereo 8-bit sample pairs over a valid/ready handshake and mixes each pair into the 9-bit mono sum that `accumulator` adds. It drives `accumulator`'s `clear` and `accumulate` strobes to frame fixed-length windows of `WINDOW` samples. It reads `current_sum` back, latches the completed window total and flags it to downstream logic.

## Interface
- `WINDOW`, default 64: samples per window. Legal range 1..128; 128 × 510 = 65280 still fits 16 bits.
- `MHz10`  in  1: system clock; all state changes on the rising edge.
- `nrst`  in  1: asynchronous, active-low reset.
- `en`  in  1: block enable, shared with `accumulator.en`.
- `sample_valid`  in  1: stereo pair present on `sample_left`/`sample_right`.
- `sample_left`  in  8: left channel, unsigned.
- `sample_right`  in  8: right channel, unsigned.
- `current_sum`  in  16: running sum fed back from `accumulator`.
- `sample_ready`  out  1: block accepts a pair this cycle.
- `sample_mono`  out  9: registered `sample_left + sample_right`, zero-extended; drives `accumulator.sample_mono`.
- `accumulate`  out  1: registered one-cycle strobe, one per accepted pair.
- `clear`  out  1: high for exactly one cycle at the start of each window.
- `window_sum`  out  16: total of the last completed window; held until the next window completes.
- `window_done`  out  1: one-cycle pulse when `window_sum` updates.
- `overrun`  out  1: one-cycle pulse when `sample_valid` is high while `en`=1 and `sample_ready`=0. The pair is dropped.

## Operation
- FSM states and per-state outputs:
  - IDLE: waits for `en`.
  - CLEAR: `clear`=1.
  - COLLECT: `sample_ready`=1.
  - DRAIN: waits one cycle for the last add to land.
  - CAPTURE: latches the total.
- `clear` and `sample_ready` decode directly from the state register.
- Transitions:
  - IDLE→CLEAR when `en`=1.
  - CLEAR→COLLECT unconditionally.
  - COLLECT→DRAIN on the accepting edge that takes the pair with `count`=`WINDOW`−1.
  - DRAIN→CAPTURE unconditionally.
  - CAPTURE→CLEAR unconditionally.
- Any state goes to IDLE when `en`=0. This takes priority over all other transitions.
- Accept means `sample_valid` && `sample_ready`. On accept:
  - `sample_mono` ← left+right.
  - `accumulate` ← 1.
  - `count` ← `count`+1.
- Otherwise `accumulate` ← 0 and `sample_mono` holds its value.
- `count` is 8 bits. It is zeroed in CLEAR and never wraps inside a window.
- On the CAPTURE→CLEAR edge: `window_sum` ← `current_sum`, and `window_done` ← 1 for one cycle.
- `en` falling mid-window:
  - The partial window is discarded.
  - `window_sum` keeps its old value and `window_done` does not fire.
  - `accumulate` is forced to 0 on the next edge.
- When `en` rises again, a fresh CLEAR starts a new window.
- `overrun` is registered. It fires in CLEAR, DRAIN and CAPTURE; it never fires in IDLE.

## Timing
- Reset values:
  - State = IDLE.
  - `count`=0.
  - `sample_mono`=0, `accumulate`=0, `clear`=0, `sample_ready`=0.
  - `window_sum`=0, `window_done`=0, `overrun`=0.
- Reset mid-window aborts immediately, with no capture.
- Pair accepted at edge E:
  - `accumulate`/`sample_mono` are valid during E→E+1.
  - `accumulator.current_sum` includes the pair after E+1.
- Back-to-back accepts on every cycle are legal throughout COLLECT.
- Last accept at E:
  - DRAIN during E→E+1.
  - CAPTURE during E+1→E+2.
  - `window_sum` updates and `window_done` is high from E+2.
  - CLEAR during E+2→E+3.
  - `sample_ready` returns at E+3.
- Window-to-window gap is 3 cycles with `sample_ready`=0.
- Startup: `en` is sampled high at edge E; `clear` is high during E→E+1 and `sample_ready` goes high from E+1.
- The accumulator's own `clear` is seen while `en`=1, so accumulator and block agree on window boundaries.

## Structure
- Shared team-12 package contents:
  - State enum (IDLE, CLEAR, COLLECT, DRAIN, CAPTURE).
  - `WINDOW_MAX`=128.
  - Width constants: 8 sample, 9 mono, 16 sum.
- Elaboration-time check: 1 ≤ `WINDOW` ≤ `WINDOW_MAX`.
- No sub-module. The mixer is a single adder and the counter is inline; both live in this module.

## Test plan
- `WINDOW`=4, L=R=255 on every cycle, back-to-back → 4 `accumulate` strobes; `window_sum`=2040 and `window_done` fire 2 cycles after the 4th accept.
- `WINDOW`=128, L=255, R=255 continuous → `window_sum`=65280, no overflow; second window also gives 65280 after the `clear`.
- `WINDOW`=4, pairs (1,2),(3,4),(5,6),(7,8) with idle cycles between → `window_sum`=36; the `sample_mono` sequence is 3, 7, 11, 15.
- `sample_valid` held high through DRAIN/CAPTURE/CLEAR → 3 `overrun` pulses; those pairs are not counted, and the next window still totals exactly `WINDOW` pairs.
- `en` dropped after 2 of 4 pairs → IDLE, `window_sum` unchanged, no `window_done`; on re-enable, `clear` is pulsed and a fresh 4-pair window completes correctly.
- `nrst` asserted mid-COLLECT → all outputs 0 asynchronously; after release with `en`=1, CLEAR then COLLECT.
